// File: rtl/axis_fifo_slice_if.sv
// AXI-Stream bundle: payload, sideband and valid/ready handshake for one stream direction.
interface axis_fifo_slice_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_fifo_slice.sv
// DEPTH-entry AXI-Stream FIFO slice. Both handshake outputs decode registered state only,
// so upstream ready never combinationally depends on downstream ready.
module axis_fifo_slice #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axis_fifo_slice_if.slave           s_axis,
  axis_fifo_slice_if.master          m_axis,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_t;

  beat_t       mem [DEPTH];
  beat_t       in_beat;
  beat_t       head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        out_of_reset;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  assign s_axis.tready = out_of_reset & ~full;
  assign m_axis.tvalid = ~empty;
  assign push          = s_axis.tvalid & s_axis.tready;
  assign pop           = m_axis.tvalid & m_axis.tready;

  assign in_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};
  assign head    = mem[rd_ptr[AW-1:0]];

  assign m_axis.tdata = head.data;
  assign m_axis.tkeep = head.keep;
  assign m_axis.tuser = head.user;
  assign m_axis.tlast = head.last;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_of_reset <= 1'b0;
      occupancy    <= '0;
      pkt_count    <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      pkt_count <= pkt_count + CW'(push & in_beat.last) - CW'(pop & head.last);
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it has been written,
  // and leaving it out keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_beat;
  end
endmodule

// File: tb/tb_axis_fifo_slice.sv
// Self-checking bench for axis_fifo_slice: DEPTH=4 and DEPTH=8 instances side by side,
// each scenario task keeps its own expected-beat queue and compares as beats leave.
module tb_axis_fifo_slice;
  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic [1:0] u;
    logic       l;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sd [2];
  logic       sk [2];
  logic [1:0] su [2];
  logic       sl [2];
  logic       sv [2];
  logic       mr [2];

  logic [2:0] occ4, pc4;
  logic [3:0] occ8, pc8;

  axis_fifo_slice_if #(.DATA_WIDTH(8), .USER_WIDTH(2)) s4 ();
  axis_fifo_slice_if #(.DATA_WIDTH(8), .USER_WIDTH(2)) m4 ();
  axis_fifo_slice_if #(.DATA_WIDTH(8), .USER_WIDTH(2)) s8 ();
  axis_fifo_slice_if #(.DATA_WIDTH(8), .USER_WIDTH(2)) m8 ();

  assign s4.tdata = sd[0]; assign s4.tkeep = sk[0]; assign s4.tuser = su[0];
  assign s4.tlast = sl[0]; assign s4.tvalid = sv[0]; assign m4.tready = mr[0];
  assign s8.tdata = sd[1]; assign s8.tkeep = sk[1]; assign s8.tuser = su[1];
  assign s8.tlast = sl[1]; assign s8.tvalid = sv[1]; assign m8.tready = mr[1];

  axis_fifo_slice #(.DATA_WIDTH(8), .USER_WIDTH(2), .DEPTH(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s4), .m_axis(m4),
    .occupancy(occ4), .pkt_count(pc4)
  );
  axis_fifo_slice #(.DATA_WIDTH(8), .USER_WIDTH(2), .DEPTH(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s8), .m_axis(m8),
    .occupancy(occ8), .pkt_count(pc8)
  );

  // Drives one cycle on instance d (0: DEPTH=4, 1: DEPTH=8), reports what the DUT showed
  // during that cycle and whether a push/pop handshake happened at the closing edge.
  task automatic drive_cycle(input int d, input logic v, input beat_t b, input logic r,
                             output logic pushed, output logic popped, output beat_t ob,
                             output int occ_o, output int pc_o,
                             output logic sr_o, output logic mv_o);
    sv[d] = v;
    {sd[d], sk[d], su[d], sl[d]} = b;
    mr[d] = r;
    if (d == 0) begin
      sr_o = s4.tready; mv_o = m4.tvalid;
      ob = {m4.tdata, m4.tkeep, m4.tuser, m4.tlast};
      occ_o = int'(occ4); pc_o = int'(pc4);
    end else begin
      sr_o = s8.tready; mv_o = m8.tvalid;
      ob = {m8.tdata, m8.tkeep, m8.tuser, m8.tlast};
      occ_o = int'(occ8); pc_o = int'(pc8);
    end
    pushed = v & sr_o;
    popped = mv_o & r;
    @(posedge aclk); #1;
  endtask

  function automatic int count_lasts(input beat_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; mr[d] = 1'b0; sd[d] = '0; sk[d] = 1'b0; su[d] = '0; sl[d] = 1'b0;
    end
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_tests++;
    if (s4.tready !== 1'b0 || s8.tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready_low: got %b/%b want 0/0", s4.tready, s8.tready);
    end
    n_tests++;
    if (m4.tvalid !== 1'b0 || m8.tvalid !== 1'b0 || occ4 !== 3'd0 || occ8 !== 4'd0) begin
      n_fail++; $display("FAIL reset_idle: tvalid %b/%b occ %0d/%0d want 0", m4.tvalid, m8.tvalid, occ4, occ8);
    end
    aresetn = 1'b1;
    #1;
    n_tests++;
    if (s4.tready !== 1'b0) begin
      n_fail++; $display("FAIL release_tready_before_edge: got %b want 0", s4.tready);
    end
    @(posedge aclk); #1;
    n_tests++;
    if (s4.tready !== 1'b1 || s8.tready !== 1'b1) begin
      n_fail++; $display("FAIL release_tready_after_edge: got %b/%b want 1/1", s4.tready, s8.tready);
    end
  endtask

  task automatic test_streaming();
    beat_t sb[$];
    int    tq[$];
    int    sent = 0, rcv = 0, exp_t;
    logic  pu, po, sr_o, mv_o;
    beat_t b, ob, exp_b;
    int    occ_o, pc_o;
    for (int c = 0; c < 40 && rcv < 16; c++) begin
      b = {8'(sent + 1), sent[0], sent[1:0], (sent % 4) == 3};
      drive_cycle(0, sent < 16, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      n_tests++;
      if (occ_o > 1) begin
        n_fail++; $display("FAIL stream_occupancy c=%0d: got %0d want <=1", c, occ_o);
      end
      if (po) begin
        exp_b = sb.pop_front(); exp_t = tq.pop_front(); rcv++;
        n_tests++;
        if (ob !== exp_b) begin
          n_fail++; $display("FAIL stream_beat %0d: got %h want %h", rcv, ob, exp_b);
        end
        n_tests++;
        if (c != exp_t + 1) begin
          n_fail++; $display("FAIL stream_latency %0d: popped cycle %0d want %0d", rcv, c, exp_t + 1);
        end
      end
      if (pu) begin
        sb.push_back(b); tq.push_back(c); sent++;
      end
    end
    sv[0] = 1'b0;
    n_tests++;
    if (rcv != 16) begin
      n_fail++; $display("FAIL stream_count: got %0d want 16", rcv);
    end
  endtask

  task automatic test_fill();
    beat_t sb[$];
    int    acc = 0;
    logic  pu, po, sr_o, mv_o, last_sr = 1'b1;
    beat_t b, ob, exp_b;
    int    occ_o, pc_o;
    for (int c = 0; c < 5; c++) begin
      b = {8'(acc + 1), 1'b1, 2'(acc), 1'b0};
      drive_cycle(0, 1'b1, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      last_sr = sr_o;
      if (pu) begin sb.push_back(b); acc++; end
    end
    n_tests++;
    if (acc != 4 || last_sr !== 1'b0) begin
      n_fail++; $display("FAIL fill_accept: got %0d beats ready %b want 4 beats ready 0", acc, last_sr);
    end
    drive_cycle(0, 1'b0, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    n_tests++;
    if (occ_o != 4 || sr_o !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: occ %0d ready %b want 4 and 0", occ_o, sr_o);
    end
    drive_cycle(0, 1'b0, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    exp_b = sb.pop_front();
    n_tests++;
    if (!po || ob !== exp_b || ob.d !== 8'h01 || sr_o !== 1'b0) begin
      n_fail++; $display("FAIL fill_pop: popped %b beat %h ready %b want 1 %h 0", po, ob, sr_o, exp_b);
    end
    drive_cycle(0, 1'b0, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    n_tests++;
    if (sr_o !== 1'b1 || occ_o != 3) begin
      n_fail++; $display("FAIL fill_ready_return: ready %b occ %0d want 1 and 3", sr_o, occ_o);
    end
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      drive_cycle(0, 1'b0, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      if (po) begin
        exp_b = sb.pop_front();
        n_tests++;
        if (ob !== exp_b) begin
          n_fail++; $display("FAIL fill_drain: got %h want %h", ob, exp_b);
        end
      end
    end
    mr[0] = 1'b0;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL fill_drain_timeout: %0d beats left want 0", sb.size());
    end
  endtask

  task automatic test_packets();
    beat_t sb[$];
    logic  lasts [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic  pu, po, sr_o, mv_o;
    beat_t b, ob, exp_b;
    int    occ_o, pc_o, npush = 0;
    for (int k = 0; k < 6; k++) begin
      b = {8'(8'h20 + k), k[0], 2'(k), lasts[k]};
      drive_cycle(1, 1'b1, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      if (pu) begin sb.push_back(b); npush++; end
    end
    drive_cycle(1, 1'b0, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    n_tests++;
    if (npush != 6 || pc_o != 3 || occ_o != 6) begin
      n_fail++; $display("FAIL pkt_fill: pushed %0d pkt %0d occ %0d want 6 3 6", npush, pc_o, occ_o);
    end
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      drive_cycle(1, 1'b0, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      n_tests++;
      if (pc_o != count_lasts(sb)) begin
        n_fail++; $display("FAIL pkt_count_drain: got %0d want %0d", pc_o, count_lasts(sb));
      end
      if (po) begin
        exp_b = sb.pop_front();
        n_tests++;
        if (ob !== exp_b) begin
          n_fail++; $display("FAIL pkt_beat: got %h want %h", ob, exp_b);
        end
      end
    end
    drive_cycle(1, 1'b0, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    mr[1] = 1'b0;
    n_tests++;
    if (sb.size() != 0 || pc_o != 0 || occ_o != 0) begin
      n_fail++; $display("FAIL pkt_empty: left %0d pkt %0d occ %0d want 0 0 0", sb.size(), pc_o, occ_o);
    end
  endtask

  task automatic test_random(input int d, input int depth);
    beat_t      sb[$];
    int         sent = 0, errs = 0, c = 0;
    logic       pu, po, sr_o, mv_o;
    beat_t      b, ob, exp_b;
    logic [11:0] rnd;
    int         occ_o, pc_o;
    for (c = 0; c < 20000; c++) begin
      if (sent == 1000 && sb.size() == 0) break;
      rnd = 12'($urandom);
      b = rnd;
      drive_cycle(d, (sent < 1000) && ($urandom_range(0, 1) == 1), b, $urandom_range(0, 1) == 1,
                  pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      n_tests++;
      if (occ_o != sb.size() || pc_o != count_lasts(sb)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand%0d_counts c=%0d: occ %0d pkt %0d want %0d %0d",
                                depth, c, occ_o, pc_o, sb.size(), count_lasts(sb));
      end
      n_tests++;
      if (sr_o !== (sb.size() < depth) || mv_o !== (sb.size() != 0)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand%0d_flags c=%0d: ready %b valid %b want %b %b",
                                depth, c, sr_o, mv_o, sb.size() < depth, sb.size() != 0);
      end
      if (mv_o && sb.size() > 0) begin
        n_tests++;
        if (ob !== sb[0]) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand%0d_beat c=%0d: got %h want %h", depth, c, ob, sb[0]);
        end
      end
      if (po && sb.size() > 0) exp_b = sb.pop_front();
      if (pu) begin sb.push_back(b); sent++; end
    end
    sv[d] = 1'b0; mr[d] = 1'b0;
    n_tests++;
    if (sent != 1000 || sb.size() != 0) begin
      n_fail++; $display("FAIL rand%0d_complete: sent %0d left %0d want 1000 0", depth, sent, sb.size());
    end
  endtask

  task automatic test_midreset();
    logic  pu, po, sr_o, mv_o, got = 1'b0;
    beat_t b, ob;
    int    occ_o, pc_o;
    for (int k = 0; k < 3; k++) begin
      b = {8'(8'h51 + k), 1'b1, 2'd0, k == 2};
      drive_cycle(0, 1'b1, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    end
    drive_cycle(0, 1'b0, b, 1'b0, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    n_tests++;
    if (occ_o != 3 || pc_o != 1) begin
      n_fail++; $display("FAIL midreset_setup: occ %0d pkt %0d want 3 1", occ_o, pc_o);
    end
    aresetn = 1'b0;
    #1;
    n_tests++;
    if (m4.tvalid !== 1'b0 || occ4 !== 3'd0 || pc4 !== 3'd0 || s4.tready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: valid %b occ %0d pkt %0d ready %b want 0 0 0 0",
                         m4.tvalid, occ4, pc4, s4.tready);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    b = {8'hAA, 1'b1, 2'd3, 1'b1};
    drive_cycle(0, 1'b1, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
    n_tests++;
    if (!pu || mv_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_push: pushed %b valid %b want 1 0", pu, mv_o);
    end
    for (int c = 0; c < 5 && !got; c++) begin
      drive_cycle(0, 1'b0, b, 1'b1, pu, po, ob, occ_o, pc_o, sr_o, mv_o);
      if (po) begin
        got = 1'b1;
        n_tests++;
        if (ob !== b) begin
          n_fail++; $display("FAIL midreset_first_beat: got %h want %h", ob, b);
        end
      end
    end
    mr[0] = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL midreset_timeout: no beat out, want 0xAA");
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_packets();
    test_random(0, 4);
    test_random(1, 8);
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
